plot_receiver: RTL and testbench

PLOT_RECEIVER -- requirements
Module: plot_receiver

---
 rtl/plot_pkg.sv | 33 +++
 rtl/plot_fifo.sv | 57 +++++
 rtl/plot_receiver.sv | 162 ++++++++++++++++
 tb/tb_plot_receiver.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_pkg.sv
// rtl/plot_pkg.sv - shared constants, types and address helper for plot_receiver
//
// Contents:
//   SCR_W_DEF, SCR_H_DEF  default screen size in pixels
//   X_W, Y_W, C_W         coordinate and colour widths
//   ADDR_W, PAYLOAD_W     framebuffer address width, FIFO payload width
//   state_t               command FSM states
//   pix_addr()            linear framebuffer address of a pixel
package plot_pkg;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int C_W       = 3;
  localparam int ADDR_W    = 15;
  localparam int PAYLOAD_W = X_W + Y_W + C_W;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  // y*scr_w + x; with a constant scr_w this reduces to shifts and adds.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] px,
                                                 input logic [Y_W-1:0] py,
                                                 input int scr_w);
    int lin;
    lin = int'(py) * scr_w + int'(px);
    return ADDR_W'(lin);
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// rtl/plot_fifo.sv - plot-command FIFO holding {x,y,colour} entries
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   push, pop   write / read strobes (ignored when full / empty)
//   din, dout   18-bit {x,y,colour} payload in, head entry out
//   full, empty occupancy flags decoded from the registered count
module plot_fifo
  import plot_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [PAYLOAD_W-1:0] din,
  output logic [PAYLOAD_W-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [PAYLOAD_W-1:0] mem [depth];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(depth));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/plot_receiver.sv
// rtl/plot_receiver.sv - buffers plot commands into framebuffer writes, with optional pixel readback
//
// Configuration macro: PLOT_READBACK_EN (defined: readback path present;
// undefined: fb_re, rd_valid, rd_colour tied to 0 and rd_* / fb_rdata ignored).
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   plot, x, y, colour     plot command, sampled on every edge with plot=1
//   busy                   FIFO full; a plot while busy is dropped
//   fb_we, fb_re           framebuffer write / read strobes (never both)
//   fb_addr, fb_wdata      framebuffer address and write colour
//   fb_rdata               framebuffer read colour, one cycle after fb_re
//   rd_req, rd_x, rd_y     readback request level and pixel
//   rd_valid, rd_colour    readback result pulse and colour
//   drop_cnt               saturating count of clipped or overflowed plots
module plot_receiver
  import plot_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SCR_W      = SCR_W_DEF,
  parameter int SCR_H      = SCR_H_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              plot,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [C_W-1:0]    colour,
  output logic              busy,
  output logic              fb_we,
  output logic              fb_re,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [C_W-1:0]    fb_wdata,
  input  logic [C_W-1:0]    fb_rdata,
  input  logic              rd_req,
  input  logic [X_W-1:0]    rd_x,
  input  logic [Y_W-1:0]    rd_y,
  output logic              rd_valid,
  output logic [C_W-1:0]    rd_colour,
  output logic [7:0]        drop_cnt
);

  state_t               state;
  state_t               state_n;
  logic                 in_range;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 drop;
  logic                 rd_start;
  logic                 rd_done;
  logic                 rd_issue;
  logic [PAYLOAD_W-1:0] head;
  logic [X_W-1:0]       head_x;
  logic [Y_W-1:0]       head_y;
  logic [C_W-1:0]       head_c;

  assign in_range = (32'(x) < SCR_W) && (32'(y) < SCR_H);
  // A full buffer rejects the plot even when this edge also pops.
  assign push     = plot && in_range && !full;
  assign drop     = plot && !push;
  assign busy     = full;

  assign head_x = head[PAYLOAD_W-1 -: X_W];
  assign head_y = head[C_W +: Y_W];
  assign head_c = head[C_W-1:0];

  plot_fifo #(
    .depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({x, y, colour}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Reads win over pending writes; writes only leave from IDLE.
  always_comb begin
    state_n  = state;
    rd_issue = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (rd_start) begin
          rd_issue = 1'b1;
          state_n  = RD_WAIT;
        end else if (!empty) begin
          pop = 1'b1;
        end
      end
      RD_WAIT: begin
        if (rd_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
      drop_cnt <= '0;
    end else begin
      fb_we <= pop;
      if (pop) begin
        fb_addr  <= pix_addr(head_x, head_y, SCR_W);
        fb_wdata <= head_c;
      end else if (rd_issue) begin
        fb_addr  <= pix_addr(rd_x, rd_y, SCR_W);
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef PLOT_READBACK_EN
  logic rd_phase;
  logic rd_oor;
  logic rd_hit;

  assign rd_hit   = (32'(rd_x) < SCR_W) && (32'(rd_y) < SCR_H);
  assign rd_start = rd_req;
  // RD_WAIT spans two edges: the first lets the framebuffer answer,
  // the second captures fb_rdata.
  assign rd_done  = rd_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_re     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_colour <= '0;
      rd_phase  <= 1'b0;
      rd_oor    <= 1'b0;
    end else begin
      fb_re    <= rd_issue && rd_hit;
      rd_valid <= (state == RD_WAIT) && rd_phase;
      rd_phase <= (state == RD_WAIT) && !rd_phase;
      if (rd_issue) rd_oor <= !rd_hit;
      if (state == RD_WAIT && rd_phase) rd_colour <= rd_oor ? '0 : fb_rdata;
    end
  end
`else
  logic unused_rb;
  assign unused_rb = ^{rd_req, rd_x, rd_y, fb_rdata};
  assign rd_start  = 1'b0;
  assign rd_done   = 1'b1;
  assign fb_re     = 1'b0;
  assign rd_valid  = 1'b0;
  assign rd_colour = '0;
`endif

endmodule

// File: tb/tb_plot_receiver.sv
// tb/tb_plot_receiver.sv - self-checking bench for plot_receiver
module tb_plot_receiver;

  localparam int DEPTH = 4;
  localparam int W     = 160;
  localparam int H     = 120;
`ifdef PLOT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        busy;
  logic        fb_we;
  logic        fb_re;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata;
  logic [2:0]  fb_rdata;
  logic        rd_req;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic        rd_valid;
  logic [2:0]  rd_colour;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  plot_receiver #(
    .FIFO_DEPTH (DEPTH),
    .SCR_W      (W),
    .SCR_H      (H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .plot      (plot),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .busy      (busy),
    .fb_we     (fb_we),
    .fb_re     (fb_re),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .fb_rdata  (fb_rdata),
    .rd_req    (rd_req),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_valid  (rd_valid),
    .rd_colour (rd_colour),
    .drop_cnt  (drop_cnt)
  );

  // Framebuffer environment: synchronous write, one-cycle read.
  logic [2:0] ram [0:W*H-1];
  always @(posedge clk) begin
    if (fb_we) ram[fb_addr] <= fb_wdata;
    if (fb_re) fb_rdata <= ram[fb_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: accepted-but-unwritten commands, expected image,
  // drop count, and the three-edge read window.
  typedef struct {
    int addr;
    int col;
  } wr_t;

  wr_t q[$];
  wr_t e_w;
  int  img [0:W*H-1];
  int  m_drop   = 0;
  int  rd_left  = 0;
  int  re_addr  = 0;
  int  pend_col = 0;
  int  val_col  = 0;
  bit  we_exp, re_exp, val_exp, zero_exp, m_issue, m_rd_idle;
  bit  started  = 1'b0;

  initial begin
    for (int i = 0; i < W*H; i++) begin
      img[i] = 0;
      ram[i] = 3'd0;
    end
    fb_rdata = 3'd0;
  end

  always @(posedge clk) begin
    started  = 1'b1;
    we_exp   = 1'b0;
    re_exp   = 1'b0;
    val_exp  = 1'b0;
    zero_exp = 1'b0;
    if (reset) begin
      q.delete();
      m_drop   = 0;
      rd_left  = 0;
      zero_exp = 1'b1;
    end else begin
      m_rd_idle = (rd_left == 0);
      m_issue   = 1'b0;
      if (rd_left == 2) begin
        rd_left = 1;
      end else if (rd_left == 1) begin
        rd_left = 0;
        val_exp = 1'b1;
        val_col = pend_col;
      end else if (RB && rd_req) begin
        m_issue = 1'b1;
        rd_left = 2;
        if (int'(rd_x) < W && int'(rd_y) < H) begin
          re_exp   = 1'b1;
          re_addr  = int'(rd_y) * W + int'(rd_x);
          pend_col = img[re_addr];
        end else begin
          pend_col = 0;
        end
      end
      we_exp = m_rd_idle && !m_issue && (q.size() > 0);
      if (plot) begin
        if (int'(x) >= W || int'(y) >= H || q.size() == DEPTH) begin
          if (m_drop < 255) m_drop++;
        end else begin
          q.push_back('{addr: int'(y) * W + int'(x), col: int'(colour)});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("fb_we", 32'(fb_we), 32'(we_exp));
      if (we_exp) begin
        e_w = q.pop_front();
        chk("fb_addr_wr", 32'(fb_addr), e_w.addr);
        chk("fb_wdata", 32'(fb_wdata), e_w.col);
        img[e_w.addr] = e_w.col;
      end
      chk("fb_re", 32'(fb_re), 32'(re_exp));
      if (re_exp) chk("fb_addr_rd", 32'(fb_addr), re_addr);
      chk("rd_valid", 32'(rd_valid), 32'(val_exp));
      if (val_exp) chk("rd_colour", 32'(rd_colour), val_col);
      chk("busy", 32'(busy), 32'(q.size() == DEPTH));
      chk("drop_cnt", 32'(drop_cnt), m_drop);
      chk("we_re_excl", 32'(fb_we & fb_re), 0);
      if (zero_exp) begin
        chk("rst_fb_addr", 32'(fb_addr), 0);
        chk("rst_fb_wdata", 32'(fb_wdata), 0);
        chk("rst_rd_colour", 32'(rd_colour), 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int wr_seen;
    int waited;
    reset = 1'b1; plot = 1'b0; x = 8'd0; y = 7'd0; colour = 3'd0;
    rd_req = 1'b0; rd_x = 8'd0; rd_y = 7'd0;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_re", 32'(fb_re), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    reset = 1'b0;
    step();

    // Single plot: write appears one edge after the push.
    plot = 1'b1; x = 8'd5; y = 7'd3; colour = 3'b100;
    step();
    plot = 1'b0;
    chk("t1_no_we_yet", 32'(fb_we), 0);
    step();
    chk("t1_we", 32'(fb_we), 1);
    chk("t1_addr", 32'(fb_addr), 485);
    chk("t1_wdata", 32'(fb_wdata), 4);
    step();

    // Clipped plots.
    plot = 1'b1; x = 8'd160; y = 7'd0; colour = 3'd7;
    step();
    x = 8'd0; y = 7'd120;
    step();
    plot = 1'b0;
    step();
    chk("t2_no_we", 32'(fb_we), 0);
    step();
    chk("t2_drop", 32'(drop_cnt), 2);

    // Overflow: six plots while reads keep the FSM away from IDLE.
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_req = 1'b1; rd_x = 8'd0; rd_y = 7'd0;
    step();
    wr_seen = 0;
    for (int i = 0; i < 6; i++) begin
      plot = 1'b1; x = 8'(20 + i); y = 7'd2; colour = 3'(i + 1);
      step();
      wr_seen += int'(fb_we);
      if (i == 3) chk("t3_busy_after4", 32'(busy), RB ? 1 : 0);
    end
    plot = 1'b0;
    chk("t3_drop", 32'(drop_cnt), RB ? 2 : 0);
`ifdef PLOT_READBACK_EN
    waited = 0;
    while (!rd_valid && waited < 10) begin
      step();
      wr_seen += int'(fb_we);
      waited++;
    end
    chk("t3_rd_pulse", 32'(rd_valid), 1);
`endif
    rd_req = 1'b0;
    repeat (8) begin
      step();
      wr_seen += int'(fb_we);
    end
    chk("t3_writes", wr_seen, RB ? 4 : 6);

    // Read with writes pending: read first, then writes resume in order.
    reset = 1'b1;
    step();
    reset = 1'b0;
    plot = 1'b1; x = 8'd10; y = 7'd1; colour = 3'd5;
    step();
    plot = 1'b0;
    step();
    step();
    plot = 1'b1; x = 8'd30; y = 7'd4; colour = 3'd2;
    step();
    x = 8'd31; colour = 3'd6; rd_req = 1'b1; rd_x = 8'd10; rd_y = 7'd1;
    step();
    plot = 1'b0;
`ifdef PLOT_READBACK_EN
    chk("t4_re", 32'(fb_re), 1);
    chk("t4_re_addr", 32'(fb_addr), 170);
    chk("t4_no_we", 32'(fb_we), 0);
    step();
    chk("t4_wait_re", 32'(fb_re), 0);
    chk("t4_wait_valid", 32'(rd_valid), 0);
    step();
    chk("t4_valid", 32'(rd_valid), 1);
    chk("t4_colour", 32'(rd_colour), 5);
    rd_req = 1'b0;
    step();
    chk("t4_resume_we", 32'(fb_we), 1);
    chk("t4_resume_addr", 32'(fb_addr), 670);
    step();
    chk("t4_next_addr", 32'(fb_addr), 671);
    chk("t4_next_wdata", 32'(fb_wdata), 6);

    // Out-of-range readback: no framebuffer access, colour 0, same timing.
    rd_req = 1'b1; rd_x = 8'd200; rd_y = 7'd0;
    step();
    chk("t4b_no_re", 32'(fb_re), 0);
    step();
    step();
    chk("t4b_valid", 32'(rd_valid), 1);
    chk("t4b_colour", 32'(rd_colour), 0);
    rd_req = 1'b0;
    step();
`else
    chk("t4_re_off", 32'(fb_re), 0);
    chk("t4_we_a", 32'(fb_we), 1);
    chk("t4_addr_a", 32'(fb_addr), 670);
    step();
    chk("t4_we_b", 32'(fb_we), 1);
    chk("t4_addr_b", 32'(fb_addr), 671);
    step();
    step();
    chk("t4_valid_off", 32'(rd_valid), 0);
    chk("t4_colour_off", 32'(rd_colour), 0);
    rd_req = 1'b0;
    step();
`endif

    // Reset while a read is in flight.
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_req = 1'b1; rd_x = 8'd3; rd_y = 7'd3;
    step();
    for (int i = 0; i < 4; i++) begin
      plot = 1'b1; x = 8'(40 + i); y = 7'd9; colour = 3'd7;
      step();
    end
    plot = 1'b0;
    chk("t5_busy_before", 32'(busy), RB ? 1 : 0);
`ifdef PLOT_READBACK_EN
    waited = 0;
    while (!fb_re && waited < 10) begin
      step();
      waited++;
    end
    chk("t5_in_read", 32'(fb_re), 1);
`endif
    reset = 1'b1; rd_req = 1'b0;
    step();
    chk("t5_busy", 32'(busy), 0);
    chk("t5_we", 32'(fb_we), 0);
    chk("t5_re", 32'(fb_re), 0);
    chk("t5_valid", 32'(rd_valid), 0);
    chk("t5_addr", 32'(fb_addr), 0);
    chk("t5_wdata", 32'(fb_wdata), 0);
    chk("t5_colour", 32'(rd_colour), 0);
    chk("t5_drop", 32'(drop_cnt), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_valid", 32'(rd_valid), 0);
    end

    // drop_cnt saturation.
    plot = 1'b1; x = 8'd200; y = 7'd0;
    repeat (260) step();
    plot = 1'b0;
    step();
    chk("t6_drop_sat", 32'(drop_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
